// File: rtl/jtag_1149_d10_slv_rsp_tx.sv
// Slave-side response packet transmitter.
// Frames SOP/type/ch/payload/CRC-32/EOP and fills idle time with K28.5.
module jtag_1149_d10_slv_rsp_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int SCAN_WIDTH = 32,
    parameter int CRC_WIDTH  = 32,
    parameter int MIN_IDLE   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rsp_req,
    input  logic [DATA_WIDTH-1:0] rsp_pkt_type,
    input  logic [DATA_WIDTH-1:0] rsp_ch_sel,
    input  logic [SCAN_WIDTH-1:0] rsp_data,
    input  logic [2:0]            rsp_byte_cnt,
    output logic                  rsp_ack,
    output logic                  rsp_done,
    output logic [DATA_WIDTH-1:0] tx_byte,
    output logic                  tx_kchar,
    output logic                  tx_byte_vld,
    input  logic                  tx_byte_rdy,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SOP  = 3'd1;
    localparam logic [2:0] S_TYPE = 3'd2;
    localparam logic [2:0] S_CH   = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;
    localparam logic [2:0] S_CRC  = 3'd5;
    localparam logic [2:0] S_EOP  = 3'd6;
    localparam logic [2:0] S_GAP  = 3'd7;

    localparam logic [7:0] K_SOP  = 8'hFB;
    localparam logic [7:0] K_EOP  = 8'hFD;
    localparam logic [7:0] K_IDLE = 8'hBC;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [3:0]  MIN_C    = 4'(MIN_IDLE);

    logic [2:0]            state;
    logic                  vld_q;
    logic [3:0]            idle_cnt;
    logic [2:0]            byte_idx;
    logic [7:0]            type_q;
    logic [7:0]            ch_q;
    logic [SCAN_WIDTH-1:0] data_q;
    logic [2:0]            len_q;
    logic [CRC_WIDTH-1:0]  crc_q;
    logic [CRC_WIDTH-1:0]  crc_out;
    logic                  ack_q;
    logic                  done_q;
    logic [CNT_WIDTH-1:0]  pkt_q;
    logic                  xfer;
    logic                  gap_done;
    logic                  capture;

    // MSB-first CRC-32 advance by one byte
    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = c ^ {b, 24'h0};
        for (int i = 0; i < 8; i++) begin
            r = r[31] ? ({r[30:0], 1'b0} ^ CRC_POLY) : {r[30:0], 1'b0};
        end
        return r;
    endfunction

    assign xfer     = vld_q & tx_byte_rdy;
    assign gap_done = (idle_cnt + 4'd1) >= MIN_C;
    assign crc_out  = ~crc_q;

    // A waiting request is taken either from IDLE once the gap is met, or
    // on the very idle transfer that completes the gap, so back-to-back
    // packets are separated by exactly MIN_IDLE idles.
    assign capture = rsp_req &
                     (((state == S_IDLE) && (idle_cnt >= MIN_C)) ||
                      ((state == S_GAP) && xfer && gap_done));

    assign tx_byte_vld = vld_q;
    assign rsp_ack     = ack_q;
    assign rsp_done    = done_q;
    assign busy        = (state != S_IDLE);
    assign pkt_cnt     = pkt_q;

    // Character presented to the encoder, held while the state holds
    always_comb begin
        tx_byte  = K_IDLE;
        tx_kchar = 1'b1;
        case (state)
            S_SOP: begin
                tx_byte  = K_SOP;
                tx_kchar = 1'b1;
            end
            S_TYPE: begin
                tx_byte  = type_q;
                tx_kchar = 1'b0;
            end
            S_CH: begin
                tx_byte  = ch_q;
                tx_kchar = 1'b0;
            end
            S_PAY: begin
                tx_byte  = data_q[{byte_idx[1:0], 3'b000} +: 8];
                tx_kchar = 1'b0;
            end
            S_CRC: begin
                tx_byte  = crc_out[{~byte_idx[1:0], 3'b000} +: 8];
                tx_kchar = 1'b0;
            end
            S_EOP: begin
                tx_byte  = K_EOP;
                tx_kchar = 1'b1;
            end
            default: begin
                tx_byte  = K_IDLE;
                tx_kchar = 1'b1;
            end
        endcase
    end

    // Link is always offered a character once out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= 1'b1;
        end
    end

    // Request capture: fields frozen at ack time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q <= '0;
            ch_q   <= '0;
            data_q <= '0;
            len_q  <= '0;
            ack_q  <= 1'b0;
        end else begin
            ack_q <= capture;
            if (capture) begin
                type_q <= rsp_pkt_type;
                ch_q   <= rsp_ch_sel;
                data_q <= rsp_data;
                len_q  <= (rsp_byte_cnt > 3'd4) ? 3'd4 : rsp_byte_cnt;
            end
        end
    end

    // Framing state machine, CRC accumulation and packet counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idle_cnt <= MIN_C;
            byte_idx <= '0;
            crc_q    <= '1;
            done_q   <= 1'b0;
            pkt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (xfer && idle_cnt != 4'd15) begin
                        idle_cnt <= idle_cnt + 4'd1;
                    end
                    if (capture) begin
                        crc_q <= '1;
                        state <= S_SOP;
                    end
                end
                S_SOP: begin
                    if (xfer) begin
                        state <= S_TYPE;
                    end
                end
                S_TYPE: begin
                    if (xfer) begin
                        crc_q <= crc_step(crc_q, type_q);
                        state <= S_CH;
                    end
                end
                S_CH: begin
                    if (xfer) begin
                        crc_q    <= crc_step(crc_q, ch_q);
                        byte_idx <= '0;
                        state    <= (len_q == 3'd0) ? S_CRC : S_PAY;
                    end
                end
                S_PAY: begin
                    if (xfer) begin
                        crc_q <= crc_step(crc_q, tx_byte);
                        if (byte_idx + 3'd1 == len_q) begin
                            byte_idx <= '0;
                            state    <= S_CRC;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                S_CRC: begin
                    if (xfer) begin
                        if (byte_idx == 3'd3) begin
                            byte_idx <= '0;
                            state    <= S_EOP;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                S_EOP: begin
                    if (xfer) begin
                        done_q   <= 1'b1;
                        idle_cnt <= '0;
                        state    <= S_GAP;
                        if (pkt_q != '1) begin
                            pkt_q <= pkt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    if (xfer) begin
                        idle_cnt <= idle_cnt + 4'd1;
                        if (gap_done) begin
                            if (capture) begin
                                crc_q <= '1;
                                state <= S_SOP;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_1149_d10_slv_rsp_tx.sv
// Bench for the response transmitter.
// Compares captured link characters against a packet/CRC reference model.
module tb_jtag_1149_d10_slv_rsp_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rsp_req;
    logic [7:0]  rsp_pkt_type;
    logic [7:0]  rsp_ch_sel;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_byte_cnt;
    logic        rsp_ack;
    logic        rsp_done;
    logic [7:0]  tx_byte;
    logic        tx_kchar;
    logic        tx_byte_vld;
    logic        tx_byte_rdy;
    logic        busy;
    logic [15:0] pkt_cnt;

    jtag_1149_d10_slv_rsp_tx dut (
        .clk          (clk),
        .rst          (rst),
        .rsp_req      (rsp_req),
        .rsp_pkt_type (rsp_pkt_type),
        .rsp_ch_sel   (rsp_ch_sel),
        .rsp_data     (rsp_data),
        .rsp_byte_cnt (rsp_byte_cnt),
        .rsp_ack      (rsp_ack),
        .rsp_done     (rsp_done),
        .tx_byte      (tx_byte),
        .tx_kchar     (tx_kchar),
        .tx_byte_vld  (tx_byte_vld),
        .tx_byte_rdy  (tx_byte_rdy),
        .busy         (busy),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int stall_err = 0;
    int n_stall = 0;
    int exp_pkts = 0;
    bit rand_rdy = 0;
    logic prev_stall = 1'b0;
    logic [8:0] prev_chr = 9'h0;

    logic [8:0] rx_q[$];
    int         rxc_q[$];
    int         ack_q[$];
    int         done_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    // Link monitor: records every transfer and checks stall stability
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && ({tx_kchar, tx_byte} !== prev_chr)) stall_err++;
            prev_stall = tx_byte_vld && !tx_byte_rdy;
            if (prev_stall) n_stall++;
            prev_chr = {tx_kchar, tx_byte};
            if (tx_byte_vld && tx_byte_rdy) begin
                rx_q.push_back({tx_kchar, tx_byte});
                rxc_q.push_back(cyc);
            end
            if (rsp_ack) ack_q.push_back(cyc);
            if (rsp_done) done_q.push_back(cyc);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rand_rdy) tx_byte_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rxc_q.delete();
        ack_q.delete();
        done_q.delete();
    endtask

    function automatic logic [31:0] ref_crc(input logic [7:0] m[$]);
        logic [31:0] crc;
        logic        fb;
        crc = 32'hFFFFFFFF;
        foreach (m[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[31] ^ m[i][b];
                crc = {crc[30:0], 1'b0};
                if (fb) crc = crc ^ 32'h04C11DB7;
            end
        end
        return ~crc;
    endfunction

    task automatic build_exp(input logic [7:0] t, input logic [7:0] c,
                             input logic [31:0] d, input int n);
        logic [7:0]  msg[$];
        logic [31:0] crc;
        int          nn;
        nn = (n > 4) ? 4 : n;
        msg.push_back(t);
        msg.push_back(c);
        for (int i = 0; i < nn; i++) msg.push_back(8'(d >> (8 * i)));
        crc = ref_crc(msg);
        exp_q.delete();
        exp_q.push_back(9'h1FB);
        foreach (msg[i]) exp_q.push_back({1'b0, msg[i]});
        for (int i = 3; i >= 0; i--) exp_q.push_back({1'b0, 8'(crc >> (8 * i))});
        exp_q.push_back(9'h1FD);
    endtask

    task automatic extract(input int from, output int sop_i, output int eop_i);
        got_q.delete();
        sop_i = -1;
        eop_i = -1;
        for (int i = from; i < rx_q.size(); i++) begin
            if (sop_i < 0 && rx_q[i] == 9'h1FB) sop_i = i;
            if (sop_i >= 0) begin
                got_q.push_back(rx_q[i]);
                if (rx_q[i] == 9'h1FD) begin
                    eop_i = i;
                    break;
                end
            end
        end
    endtask

    function automatic int pkt_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [8:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 9'hxxx;
    endfunction

    function automatic logic [8:0] exp_at(input int i);
        return (i < exp_q.size()) ? exp_q[i] : 9'hxxx;
    endfunction

    task automatic scramble();
        rsp_pkt_type = 8'($urandom);
        rsp_ch_sel   = 8'($urandom);
        rsp_data     = $urandom;
        rsp_byte_cnt = 3'($urandom);
    endtask

    task automatic send(input logic [7:0] t, input logic [7:0] c,
                        input logic [31:0] d, input logic [2:0] n);
        int k;
        int d0;
        rsp_pkt_type = t;
        rsp_ch_sel   = c;
        rsp_data     = d;
        rsp_byte_cnt = n;
        rsp_req      = 1'b1;
        d0 = done_q.size();
        k = 0;
        do begin
            cycle();
            k++;
        end while (!rsp_ack && k < 64);
        rsp_req = 1'b0;
        if (!rsp_ack) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_timeout: rsp_ack=%b after %0d cycles, required 1", rsp_ack, k);
            return;
        end
        scramble();
        k = 0;
        while (done_q.size() == d0 && k < 600) begin
            cycle();
            k++;
        end
        if (done_q.size() == d0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: %0d done pulses after %0d cycles, required %0d", done_q.size(), k, d0 + 1);
            return;
        end
        exp_pkts++;
        cycle();
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (tx_byte_vld !== 1'b0 || rsp_ack !== 1'b0 || rsp_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: vld/ack/done=%b%b%b, required 000", tx_byte_vld, rsp_ack, rsp_done);
        end
        n_cmp++;
        if ({tx_kchar, tx_byte} !== 9'h1BC) begin
            n_err++;
            $display("FAIL reset_char: got %h, required 1bc", {tx_kchar, tx_byte});
        end
        n_cmp++;
        if (busy !== 1'b0 || pkt_cnt !== 16'h0) begin
            n_err++;
            $display("FAIL reset_stat: busy=%b pkt_cnt=%h, required 0 0000", busy, pkt_cnt);
        end
        rst = 1'b0;
        clear_mon();
        repeat (12) cycle();
        bad = 0;
        foreach (rx_q[i]) if (rx_q[i] !== 9'h1BC) bad++;
        n_cmp++;
        if (bad != 0 || rx_q.size() < 10) begin
            n_err++;
            $display("FAIL idle_stream: %0d transfers with %0d non-idle, required >=10 and 0", rx_q.size(), bad);
        end
        n_cmp++;
        if (tx_byte_vld !== 1'b1 || busy !== 1'b0 || pkt_cnt !== 16'h0) begin
            n_err++;
            $display("FAIL idle_stat: vld=%b busy=%b pkt_cnt=%h, required 1 0 0000", tx_byte_vld, busy, pkt_cnt);
        end
    endtask

    task automatic test_basic();
        int s;
        int e;
        int d;
        clear_mon();
        send(8'h20, 8'h01, 32'hDEADBEEF, 3'd4);
        build_exp(8'h20, 8'h01, 32'hDEADBEEF, 4);
        extract(0, s, e);
        d = pkt_diff();
        n_cmp++;
        if (d !== -1) begin
            n_err++;
            $display("FAIL basic_pkt: char %0d got %h, required %h (len %0d vs %0d)", d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        n_cmp++;
        if (ack_q.size() != 1 || done_q.size() != 1 || done_q[0] - ack_q[0] != 12) begin
            n_err++;
            $display("FAIL basic_latency: acks=%0d dones=%0d delta=%0d, required 1 1 12", ack_q.size(), done_q.size(), (done_q.size() > 0 && ack_q.size() > 0) ? done_q[0] - ack_q[0] : -1);
        end
        n_cmp++;
        if (pkt_cnt !== 16'(exp_pkts)) begin
            n_err++;
            $display("FAIL basic_cnt: pkt_cnt=%0d, required %0d", pkt_cnt, exp_pkts);
        end
    endtask

    task automatic test_short();
        int s;
        int e;
        int d;
        logic [7:0]  t;
        logic [7:0]  c;
        logic [31:0] w;
        clear_mon();
        send(8'h05, 8'h03, 32'h12345678, 3'd0);
        build_exp(8'h05, 8'h03, 32'h12345678, 0);
        extract(0, s, e);
        d = pkt_diff();
        n_cmp++;
        if (d !== -1) begin
            n_err++;
            $display("FAIL empty_pkt: char %0d got %h, required %h (len %0d vs %0d)", d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        n_cmp++;
        if (done_q.size() != 1 || ack_q.size() != 1 || done_q[0] - ack_q[0] != 8) begin
            n_err++;
            $display("FAIL empty_latency: delta=%0d, required 8", (done_q.size() > 0 && ack_q.size() > 0) ? done_q[0] - ack_q[0] : -1);
        end
        t = 8'($urandom);
        c = 8'($urandom);
        w = $urandom;
        clear_mon();
        send(t, c, w, 3'd7);
        build_exp(t, c, w, 7);
        extract(0, s, e);
        d = pkt_diff();
        n_cmp++;
        if (d !== -1) begin
            n_err++;
            $display("FAIL clamp_pkt: char %0d got %h, required %h (len %0d vs %0d)", d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        n_cmp++;
        if (got_q.size() - 8 != 4) begin
            n_err++;
            $display("FAIL clamp_len: %0d payload bytes, required 4", got_q.size() - 8);
        end
    endtask

    task automatic test_stall();
        int s;
        int e;
        int d;
        logic [7:0]  t;
        logic [7:0]  c;
        logic [31:0] w;
        logic [2:0]  n;
        stall_err = 0;
        n_stall = 0;
        rand_rdy = 1;
        for (int p = 0; p < 4; p++) begin
            t = 8'($urandom);
            c = 8'($urandom);
            w = $urandom;
            n = 3'($urandom_range(0, 7));
            clear_mon();
            send(t, c, w, n);
            build_exp(t, c, w, int'(n));
            extract(0, s, e);
            d = pkt_diff();
            n_cmp++;
            if (d !== -1) begin
                n_err++;
                $display("FAIL stall_pkt%0d: char %0d got %h, required %h (len %0d vs %0d)", p, d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
            end
        end
        rand_rdy = 0;
        tx_byte_rdy = 1'b1;
        cycle();
        n_cmp++;
        if (stall_err != 0 || n_stall == 0) begin
            n_err++;
            $display("FAIL stall_hold: %0d changes over %0d stalls, required 0 over >0", stall_err, n_stall);
        end
    endtask

    task automatic test_back_to_back();
        int s1;
        int e1;
        int s2;
        int e2;
        int d;
        int k;
        int acks;
        logic [7:0]  ta;
        logic [7:0]  tb;
        logic [31:0] wa;
        logic [31:0] wb;
        ta = 8'($urandom);
        tb = 8'($urandom);
        wa = $urandom;
        wb = $urandom;
        clear_mon();
        rsp_pkt_type = ta;
        rsp_ch_sel   = 8'h11;
        rsp_data     = wa;
        rsp_byte_cnt = 3'd3;
        rsp_req      = 1'b1;
        acks = 0;
        k = 0;
        while (acks < 2 && k < 200) begin
            cycle();
            k++;
            if (rsp_ack) begin
                acks++;
                if (acks == 1) begin
                    rsp_pkt_type = tb;
                    rsp_ch_sel   = 8'h22;
                    rsp_data     = wb;
                    rsp_byte_cnt = 3'd2;
                end
            end
        end
        rsp_req = 1'b0;
        scramble();
        k = 0;
        while (done_q.size() < 2 && k < 200) begin
            cycle();
            k++;
        end
        n_cmp++;
        if (acks != 2 || done_q.size() != 2) begin
            n_err++;
            $display("FAIL b2b_count: acks=%0d dones=%0d, required 2 2", acks, done_q.size());
        end
        exp_pkts += done_q.size();
        build_exp(ta, 8'h11, wa, 3);
        extract(0, s1, e1);
        d = pkt_diff();
        n_cmp++;
        if (d !== -1) begin
            n_err++;
            $display("FAIL b2b_pkt1: char %0d got %h, required %h", d, got_at(d), exp_at(d));
        end
        build_exp(tb, 8'h22, wb, 2);
        extract((e1 < 0) ? rx_q.size() : e1 + 1, s2, e2);
        d = pkt_diff();
        n_cmp++;
        if (d !== -1) begin
            n_err++;
            $display("FAIL b2b_pkt2: char %0d got %h, required %h", d, got_at(d), exp_at(d));
        end
        n_cmp++;
        if (e1 < 0 || s2 < 0 || s2 - e1 - 1 != 2) begin
            n_err++;
            $display("FAIL b2b_gap: %0d idles between packets, required 2", (e1 >= 0 && s2 >= 0) ? s2 - e1 - 1 : -1);
        end
        n_cmp++;
        if (e1 < 0 || e1 + 2 >= rxc_q.size() || ack_q.size() < 2 || ack_q[1] <= rxc_q[e1 + 2]) begin
            n_err++;
            $display("FAIL b2b_ack: second ack cycle %0d, required after idle cycle %0d", (ack_q.size() > 1) ? ack_q[1] : -1, (e1 >= 0 && e1 + 2 < rxc_q.size()) ? rxc_q[e1 + 2] : -1);
        end
        n_cmp++;
        if (pkt_cnt !== 16'(exp_pkts)) begin
            n_err++;
            $display("FAIL b2b_cnt: pkt_cnt=%0d, required %0d", pkt_cnt, exp_pkts);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        int e;
        int d;
        int k;
        clear_mon();
        rsp_pkt_type = 8'h7E;
        rsp_ch_sel   = 8'h42;
        rsp_data     = 32'hCAFEF00D;
        rsp_byte_cnt = 3'd4;
        rsp_req      = 1'b1;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!rsp_ack && k < 64);
        rsp_req = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if (rx_q.size() == 0 || rx_q[rx_q.size() - 1] !== 9'h07E) begin
            n_err++;
            $display("FAIL mid_reach_ch: last char %h, required 07e", (rx_q.size() > 0) ? rx_q[rx_q.size() - 1] : 9'h0);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx_byte_vld, tx_kchar, tx_byte, busy, rsp_ack, rsp_done} !== {1'b0, 9'h1BC, 3'b000}) begin
            n_err++;
            $display("FAIL mid_async: vld=%b chr=%h busy=%b ack=%b done=%b, required 0 1bc 0 0 0", tx_byte_vld, {tx_kchar, tx_byte}, busy, rsp_ack, rsp_done);
        end
        n_cmp++;
        if (pkt_cnt !== 16'h0) begin
            n_err++;
            $display("FAIL mid_cnt_reset: pkt_cnt=%0d, required 0", pkt_cnt);
        end
        exp_pkts = 0;
        cycle();
        cycle();
        rst = 1'b0;
        clear_mon();
        send(8'h33, 8'h44, 32'h0BADCAFE, 3'd3);
        build_exp(8'h33, 8'h44, 32'h0BADCAFE, 3);
        extract(0, s, e);
        d = pkt_diff();
        n_cmp++;
        if (d !== -1) begin
            n_err++;
            $display("FAIL mid_next_pkt: char %0d got %h, required %h", d, got_at(d), exp_at(d));
        end
        n_cmp++;
        if (pkt_cnt !== 16'(exp_pkts)) begin
            n_err++;
            $display("FAIL mid_cnt: pkt_cnt=%0d, required %0d", pkt_cnt, exp_pkts);
        end
    endtask

    initial begin
        rst = 1'b1;
        rsp_req = 1'b0;
        rsp_pkt_type = 8'h0;
        rsp_ch_sel = 8'h0;
        rsp_data = 32'h0;
        rsp_byte_cnt = 3'd0;
        tx_byte_rdy = 1'b1;
        test_reset();
        test_basic();
        test_short();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
